// File: rtl/h3_pkg.sv
// Shared definitions for the Hamming(7,4) scrubber: code geometry, codeword
// type, scrubber FSM states and the syndrome helper used by the corrector.
package h3_pkg;

  localparam int N = 7;  // codeword width
  localparam int K = 4;  // information bits
  localparam int R = 3;  // parity bits

  typedef logic [6:0] h3_cw_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_CHECK,
    S_WR_REQ,
    S_NEXT
  } scrub_state_t;

  // Bit i of the codeword is Hamming position i+1 (p1 p2 d1 p3 d2 d3 d4).
  // A nonzero syndrome is the 1-based position of the flipped bit.
  function automatic logic [R-1:0] h3_syndrome(input h3_cw_t cw);
    logic [R-1:0] s;
    s[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return s;
  endfunction

endpackage

// File: rtl/h3_scrubber_7_4_corr.sv
// Combinational Hamming(7,4) single-error corrector. Any nonzero syndrome is
// treated as a single-bit error; double errors get miscorrected by design.
module h3_scrubber_7_4_corr
  import h3_pkg::*;
(
  input  h3_cw_t cw_i,
  output h3_cw_t cw_o,
  output logic   sec_o
);

  logic [R-1:0] syn;
  h3_cw_t       flip;

  // Decode the syndrome into a one-hot flip mask and apply it
  always_comb begin
    syn  = h3_syndrome(cw_i);
    flip = '0;
    if (syn != '0) flip = h3_cw_t'(1) << (syn - R'(1));
    cw_o  = cw_i ^ flip;
    sec_o = (syn != '0);
  end

endmodule

// File: rtl/h3_scrubber_7_4.sv
// Background scrubber: walks every address, reads the codeword, runs it
// through the corrector and writes back only words that needed a fix.
// Memory access is shared with the functional path via req/gnt.
module h3_scrubber_7_4 #(
  parameter int N      = 7,
  parameter int K      = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              enable_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [N-1:0]      mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic [N-1:0]      mem_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              sec_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [CNT_W-1:0]  sec_count_o
);

  import h3_pkg::*;

  if (N != 7 || K != 4 || DEPTH < 2 || RD_LAT < 1) begin : g_param_chk
    $error("h3_scrubber_7_4: unsupported parameter set");
  end

  localparam int                LAT_W     = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT);

  scrub_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  h3_cw_t            rdata_q, rdata_d;
  h3_cw_t            wdata_q, wdata_d;
  logic              sec_q, sec_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  h3_cw_t corr_cw;
  logic   corr_sec;

  h3_scrubber_7_4_corr u_corr (
    .cw_i  (rdata_q),
    .cw_o  (corr_cw),
    .sec_o (corr_sec)
  );

  // State register and datapath flops; reset aborts any access in flight
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      lat_q      <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      sec_q      <= 1'b0;
      err_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lat_q      <= lat_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      sec_q      <= sec_d;
      err_addr_q <= err_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic and per-state memory handshake outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lat_d      = lat_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    sec_d      = 1'b0;
    err_addr_d = err_addr_q;
    cnt_d      = cnt_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i || enable_i) begin
          state_d = S_RD_REQ;
          addr_d  = '0;
        end
      end
      S_RD_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          state_d = S_RD_WAIT;
          lat_d   = LAT_W'(1);
        end
      end
      S_RD_WAIT: begin
        // lat_q counts cycles since acceptance; data lands at RD_LAT
        if (lat_q == LAT_LAST) begin
          rdata_d = mem_rdata_i;
          state_d = S_CHECK;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_CHECK: begin
        if (corr_sec) begin
          wdata_d = corr_cw;
          state_d = S_WR_REQ;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WR_REQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_gnt_i) begin
          sec_d      = 1'b1;
          err_addr_d = addr_q;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          done_o  = 1'b1;
          addr_d  = '0;
          state_d = enable_i ? S_RD_REQ : S_IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_RD_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != S_IDLE);
  assign sec_o       = sec_q;
  assign err_addr_o  = err_addr_q;
  assign sec_count_o = cnt_q;

endmodule

// File: doc/h3_scrubber_7_4.md
Name: h3_scrubber_7_4

Overview:
- Background scrubber for a memory holding Hamming(7,4) codewords: one per address, SEC capability.
- Walks the memory address by address and reads each codeword.
- Passes each codeword through the existing combinational 7/4 correction block and writes the corrected word back only when a single-bit error is flagged.
- Sits upstream of the corrector, feeding it, and consumes its output. Shares the memory port with the functional path through a request/grant handshake.

Parameters:
- N, 7, codeword width.
- K, 4, information bits.
- DEPTH, 16, number of codewords scrubbed; must be ≥2.
- ADDR_W, $clog2(DEPTH), address width.
- CNT_W, 16, correction counter width.
- RD_LAT, 1, memory read latency in cycles after an accepted read; must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  pulse: launch one full pass; ignored while busy_o=1
- enable_i  in  1  level: continuous scrubbing; a new pass starts automatically after each pass
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  1=write, 0=read; valid while mem_req_o=1
- mem_addr_o  out  ADDR_W  access address
- mem_wdata_o  out  N  write data (corrected codeword)
- mem_gnt_i  in  1  access accepted this cycle when mem_req_o & mem_gnt_i
- mem_rdata_i  in  N  read data, valid RD_LAT cycles after read acceptance
- busy_o  out  1  pass in progress
- done_o  out  1  one-cycle pulse at end of each pass
- sec_o  out  1  one-cycle pulse when a correction is written back
- err_addr_o  out  ADDR_W  address of the most recent correction
- sec_count_o  out  CNT_W  saturating count of corrections since reset

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; internal address 0.
- States: IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
- IDLE:
  - start_i=1 or enable_i=1 → RD_REQ, addr=0, busy_o=1 from the next cycle.
  - start_i while busy_o=1 is dropped, not queued.
- RD_REQ:
  - mem_req_o=1, mem_we_o=0, mem_addr_o=addr.
  - Hold these until mem_gnt_i=1, then → RD_WAIT.
  - Request/address/we must not change while waiting for grant.
- RD_WAIT:
  - Count RD_LAT cycles from acceptance.
  - Register mem_rdata_i on the cycle it is valid, then → CHECK.
- CHECK:
  - Registered word drives the corrector sub-module.
  - Corrector sec=1 → WR_REQ with wdata=corrected word; else → NEXT.
- WR_REQ:
  - mem_req_o=1, mem_we_o=1, address unchanged; hold until mem_gnt_i.
  - On grant: sec_o pulse for 1 cycle, err_addr_o=addr, sec_count_o increments (saturates at 2^CNT_W-1), then → NEXT.
- NEXT:
  - If addr≠DEPTH-1: addr+1 → RD_REQ.
  - If addr=DEPTH-1 (wrap): done_o pulse this cycle, addr=0.
    - enable_i=1 → RD_REQ (busy_o stays 1).
    - Otherwise → IDLE, busy_o=0 next cycle.
- enable_i deasserted mid-pass: the current pass completes.
- Async reset mid-operation aborts immediately; any in-flight read data arriving after reset is ignored.
- Latency per clean word, with grant immediate: 1 (RD_REQ) + RD_LAT + 1 (CHECK) + 1 (NEXT) cycles. A corrected word adds ≥1 cycle.
- Double-bit errors are miscorrected by Hamming(7,4); this is out of scope, and the written-back result equals the corrector output.

Decomposition:
- Shared package h3_pkg:
  - constants N=7, K=4, R=3.
  - typedef h3_cw_t = logic [6:0].
  - enum scrub_state_t for the six states.
- Sub-module: the existing combinational 7/4 correction block, instantiated once in CHECK; it supplies the corrected codeword and sec.
- FSM, address counter and saturating counter stay in this module.

Test Plan:
- Clean memory, DEPTH=16, start_i pulse, gnt tied 1, RD_LAT=1 → 16 reads, 0 writes, sec_count_o=0. done_o at cycle 1+16·4 after start; busy_o then falls.
- Addr 5 holds 7'b1010101 with bit 2 flipped (7'b1010001) → one write at addr 5 of 7'b1010101; sec_o pulse; err_addr_o=5; sec_count_o=1.
- mem_gnt_i held 0 for 10 cycles during RD_REQ at addr 3, then during WR_REQ → req/we/addr/wdata stable throughout; no extra accesses.
- enable_i=1 across 3 passes with one error at addr 15 → done_o ×3; addr wraps 15→0; sec_count_o=1 (a write-back fixes it) unless the error is re-injected each pass, then 3.
- CNT_W=2 with 5 corrupted words → sec_count_o saturates at 3.
- rst_n_i asserted asynchronously in RD_WAIT at addr 7 → all outputs 0 immediately; the next start_i restarts at addr 0.
